// File: rtl/dma_fetch_engine.sv
// Responder side of the fetch_data/ack_fetch_data handshake: copies one chunk of dwords
// from the memory read port into video BRAM. Define DMA_FETCH_BYTESWAP_EN to byte-reverse each dword.
module dma_fetch_engine #(
    parameter int MAX_LEN  = 64,
    parameter int MAX_OUTS = 4,
    parameter int BRAM_AW  = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_data,
    input  logic [63:0]        read_from,
    input  logic [BRAM_AW-1:0] write_to,
    input  logic [15:0]        length_data,
    output logic               ack_fetch_data,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [63:0]        mem_req_addr,
    input  logic               mem_rsp_valid,
    input  logic [31:0]        mem_rsp_data,
    output logic               videomem_we,
    output logic [BRAM_AW-1:0] videomem_addr,
    output logic [31:0]        videomem_wdata,
    output logic               busy,
    output logic               err
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE    = 3'd1,
        DRAIN    = 3'd2,
        ACK      = 3'd3,
        WAIT_LOW = 3'd4
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [63:0]        rd_addr_r;
    logic [BRAM_AW-1:0] wr_addr_r;
    logic [15:0]        len_r;
    logic [15:0]        issued_r;
    logic [15:0]        received_r;
    logic               rearm_r;
    logic               err_r;
    logic               vm_we_r;
    logic [BRAM_AW-1:0] vm_addr_r;
    logic [31:0]        vm_data_r;

    logic               accept_s;
    logic               bad_s;
    logic               req_valid_s;
    logic               req_fire_s;
    logic               rsp_take_s;
    logic               rsp_stray_s;
    logic [15:0]        outs_s;

    function automatic logic [31:0] lane_order(input logic [31:0] d);
`ifdef DMA_FETCH_BYTESWAP_EN
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
        return d;
`endif
    endfunction

    // Handshake qualifiers derived from registered state
    always_comb begin
        outs_s      = issued_r - received_r;
        accept_s    = (state_r == IDLE) && fetch_data && rearm_r;
        bad_s       = (length_data > 16'(MAX_LEN)) || (read_from[1:0] != 2'b00);
        req_valid_s = (state_r == ISSUE) && (issued_r < len_r) && (outs_s < 16'(MAX_OUTS));
        req_fire_s  = req_valid_s && mem_req_ready;
        rsp_take_s  = mem_rsp_valid && ((state_r == ISSUE) || (state_r == DRAIN));
        rsp_stray_s = mem_rsp_valid && !((state_r == ISSUE) || (state_r == DRAIN));
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if ((length_data == 16'd0) || bad_s) begin
                        state_s = ACK;
                    end else begin
                        state_s = ISSUE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (issued_r == len_r) begin
                    state_s = DRAIN;
                end else begin
                    state_s = ISSUE;
                end
            end
            // received only reaches len on the cycle the final BRAM write is on the bus
            DRAIN: begin
                if (received_r == len_r) begin
                    state_s = ACK;
                end else begin
                    state_s = DRAIN;
                end
            end
            ACK:      state_s = WAIT_LOW;
            WAIT_LOW: begin
                if (!fetch_data) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT_LOW;
                end
            end
            default:  state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Request side: latched chunk parameters and issue counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_r     <= 16'd0;
            rd_addr_r <= 64'd0;
            issued_r  <= 16'd0;
            rearm_r   <= 1'b1;
        end else if (accept_s) begin
            len_r     <= length_data;
            rd_addr_r <= read_from;
            issued_r  <= 16'd0;
            rearm_r   <= 1'b0;
        end else begin
            if (req_fire_s) begin
                issued_r  <= issued_r + 16'd1;
                rd_addr_r <= rd_addr_r + 64'd4;
            end
            if ((state_r == WAIT_LOW) && !fetch_data) begin
                rearm_r <= 1'b1;
            end
        end
    end

    // Response side: register each response into a BRAM write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vm_we_r    <= 1'b0;
            vm_addr_r  <= '0;
            vm_data_r  <= 32'd0;
            wr_addr_r  <= '0;
            received_r <= 16'd0;
        end else begin
            vm_we_r <= rsp_take_s;
            if (accept_s) begin
                wr_addr_r  <= write_to;
                received_r <= 16'd0;
            end else if (rsp_take_s) begin
                vm_addr_r  <= wr_addr_r;
                vm_data_r  <= lane_order(mem_rsp_data);
                wr_addr_r  <= wr_addr_r + BRAM_AW'(4);
                received_r <= received_r + 16'd1;
            end
        end
    end

    // Sticky error: stray responses win over the clear on accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (rsp_stray_s) begin
            err_r <= 1'b1;
        end else if (accept_s) begin
            err_r <= bad_s;
        end
    end

    assign ack_fetch_data = (state_r == ACK);
    assign busy           = (state_r != IDLE);
    assign mem_req_valid  = req_valid_s;
    assign mem_req_addr   = rd_addr_r;
    assign videomem_we    = vm_we_r;
    assign videomem_addr  = vm_addr_r;
    assign videomem_wdata = vm_data_r;
    assign err            = err_r;

endmodule

// File: tb/tb_dma_fetch_engine.sv
// Directed testbench for dma_fetch_engine with a small latency-configurable memory model.
module tb_dma_fetch_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_data = 1'b0;
    logic [63:0] read_from = 64'd0;
    logic [17:0] write_to = 18'd0;
    logic [15:0] length_data = 16'd0;
    logic        ack_fetch_data;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b1;
    logic [63:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        videomem_we;
    logic [17:0] videomem_addr;
    logic [31:0] videomem_wdata;
    logic        busy;
    logic        err;

    logic        mdl_valid = 1'b0;
    logic [31:0] mdl_data = 32'd0;
    logic        inj_valid = 1'b0;

    int checks = 0;
    int failures = 0;
    int lat = 1;
    int ready_mode = 0;
    int cyc = 0;
    int hs_cnt = 0;
    int rsp_cnt = 0;
    int ack_total = 0;
    int reqv_total = 0;
    int max_seen = 0;
    logic [63:0] pend_addr[$];
    int          pend_due[$];
    logic [63:0] req_log[$];
    logic [17:0] wr_a[$];
    logic [31:0] wr_d[$];

    assign mem_rsp_valid = mdl_valid | inj_valid;
    assign mem_rsp_data  = mdl_data;

    dma_fetch_engine dut (
        .clk(clk), .rst(rst), .fetch_data(fetch_data), .read_from(read_from),
        .write_to(write_to), .length_data(length_data), .ack_fetch_data(ack_fetch_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .videomem_we(videomem_we),
        .videomem_addr(videomem_addr), .videomem_wdata(videomem_wdata), .busy(busy), .err(err)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [31:0] mem_data(input logic [63:0] a);
        logic [31:0] off;
        off = a[31:0] - 32'h0000_1000;
        return 32'hA5A5_0001 + (off >> 2);
    endfunction

    function automatic logic [31:0] exp_data(input logic [63:0] a);
        logic [31:0] d;
        d = mem_data(a);
`ifdef DMA_FETCH_BYTESWAP_EN
        d = {d[7:0], d[15:8], d[23:16], d[31:24]};
`endif
        return d;
    endfunction

    // Memory model: in-order responses `lat` cycles after each accepted request
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (mem_rsp_valid) rsp_cnt = rsp_cnt + 1;
        if (mem_req_valid && mem_req_ready) begin
            hs_cnt = hs_cnt + 1;
            pend_addr.push_back(mem_req_addr);
            pend_due.push_back(cyc + lat - 1);
            req_log.push_back(mem_req_addr);
        end
        #1;
        if ((pend_due.size() > 0) && (pend_due[0] <= cyc)) begin
            mdl_valid = 1'b1;
            mdl_data  = mem_data(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            mdl_valid = 1'b0;
        end
        mem_req_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 4) == 0);
    end

    always @(negedge clk) begin
        if (videomem_we) begin
            wr_a.push_back(videomem_addr);
            wr_d.push_back(videomem_wdata);
        end
        if (ack_fetch_data) ack_total = ack_total + 1;
        if (mem_req_valid) reqv_total = reqv_total + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic start_req(input logic [63:0] src, input logic [17:0] dst, input logic [15:0] len);
        @(negedge clk);
        read_from   = src;
        write_to    = dst;
        length_data = len;
        fetch_data  = 1'b1;
    endtask

    // n = number of rising edges after the accept edge's predecessor until ack is seen
    task automatic wait_ack(input int budget, output int n);
        n = 0;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk);
            #1;
            if ((hs_cnt - rsp_cnt) > max_seen) max_seen = hs_cnt - rsp_cnt;
            if (ack_fetch_data) begin
                n = i;
                break;
            end
        end
        if (n == 0) begin
            checks++;
            failures++;
            $display("FAIL ack_timeout: no ack within %0d cycles", budget);
        end
    endtask

    task automatic release_fetch();
        @(negedge clk);
        fetch_data = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, ack_fetch_data, mem_req_valid, videomem_we, err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {busy, ack_fetch_data, mem_req_valid, videomem_we, err});
        end
        checks++;
        if ({mem_req_addr, videomem_addr, videomem_wdata} !== 114'd0) begin
            failures++;
            $display("FAIL reset_buses: req_addr %h vm_addr %h vm_data %h expected 0",
                     mem_req_addr, videomem_addr, videomem_wdata);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int n, b_req, b_wr, b_ack;
        lat = 1; ready_mode = 0;
        b_req = req_log.size(); b_wr = wr_a.size(); b_ack = ack_total;
        start_req(64'h1000, 18'h00040, 16'd1);
        wait_ack(20, n);
        checks++;
        if (n !== 4) begin failures++; $display("FAIL single_latency: got %0d expected 4", n); end
        release_fetch();
        checks++;
        if (req_log.size() - b_req !== 1) begin
            failures++; $display("FAIL single_req_count: got %0d expected 1", req_log.size() - b_req);
        end else begin
            checks++;
            if (req_log[b_req] !== 64'h1000) begin
                failures++; $display("FAIL single_req_addr: got %h expected 1000", req_log[b_req]);
            end
        end
        checks++;
        if (wr_a.size() - b_wr !== 1) begin
            failures++; $display("FAIL single_wr_count: got %0d expected 1", wr_a.size() - b_wr);
        end else begin
            checks++;
            if (wr_a[b_wr] !== 18'h00040) begin
                failures++; $display("FAIL single_wr_addr: got %h expected 00040", wr_a[b_wr]);
            end
            checks++;
            if (wr_d[b_wr] !== exp_data(64'h1000)) begin
                failures++; $display("FAIL single_wr_data: got %h expected %h", wr_d[b_wr], exp_data(64'h1000));
            end
        end
        checks++;
        if (ack_total - b_ack !== 1) begin
            failures++; $display("FAIL single_ack_count: got %0d expected 1", ack_total - b_ack);
        end
    endtask

    task automatic test_max_len();
        int n, b_req, b_wr, b_ack;
        logic [63:0] ea;
        logic [17:0] wa;
        lat = 1; ready_mode = 0;
        b_req = req_log.size(); b_wr = wr_a.size(); b_ack = ack_total;
        start_req(64'h1000, 18'h3FFF0, 16'd64);
        wait_ack(400, n);
        release_fetch();
        checks++;
        if ((req_log.size() - b_req !== 64) || (wr_a.size() - b_wr !== 64)) begin
            failures++;
            $display("FAIL maxlen_counts: reqs %0d writes %0d expected 64 64",
                     req_log.size() - b_req, wr_a.size() - b_wr);
        end else begin
            for (int i = 0; i < 64; i++) begin
                ea = 64'h1000 + 64'(i * 4);
                wa = 18'h3FFF0 + 18'(i * 4);
                checks++;
                if ((req_log[b_req + i] !== ea) || (wr_a[b_wr + i] !== wa) || (wr_d[b_wr + i] !== exp_data(ea))) begin
                    failures++;
                    $display("FAIL maxlen_item%0d: req %h wr %h data %h expected %h %h %h", i,
                             req_log[b_req + i], wr_a[b_wr + i], wr_d[b_wr + i], ea, wa, exp_data(ea));
                end
            end
        end
        checks++;
        if (ack_total - b_ack !== 1) begin
            failures++; $display("FAIL maxlen_ack_count: got %0d expected 1", ack_total - b_ack);
        end
    endtask

    task automatic test_backpressure();
        int n, b_wr, b_ack;
        logic [63:0] ea;
        lat = 5; ready_mode = 1; max_seen = 0;
        b_wr = wr_a.size(); b_ack = ack_total;
        start_req(64'h2000, 18'h00100, 16'd10);
        wait_ack(500, n);
        release_fetch();
        checks++;
        if (max_seen > 4) begin failures++; $display("FAIL bp_outstanding: got %0d expected <=4", max_seen); end
        checks++;
        if (wr_a.size() - b_wr !== 10) begin
            failures++; $display("FAIL bp_wr_count: got %0d expected 10", wr_a.size() - b_wr);
        end else begin
            for (int i = 0; i < 10; i++) begin
                ea = 64'h2000 + 64'(i * 4);
                checks++;
                if ((wr_a[b_wr + i] !== 18'h00100 + 18'(i * 4)) || (wr_d[b_wr + i] !== exp_data(ea))) begin
                    failures++;
                    $display("FAIL bp_item%0d: wr %h data %h expected %h %h", i, wr_a[b_wr + i],
                             wr_d[b_wr + i], 18'h00100 + 18'(i * 4), exp_data(ea));
                end
            end
        end
        checks++;
        if (ack_total - b_ack !== 1) begin
            failures++; $display("FAIL bp_ack_count: got %0d expected 1", ack_total - b_ack);
        end
        // Slow memory with a ready port: the outstanding cap must be the limiter
        lat = 12; ready_mode = 0; max_seen = 0;
        b_wr = wr_a.size();
        start_req(64'h3000, 18'h00200, 16'd8);
        wait_ack(500, n);
        release_fetch();
        checks++;
        if (max_seen !== 4) begin failures++; $display("FAIL cap_outstanding: got %0d expected 4", max_seen); end
        checks++;
        if (wr_a.size() - b_wr !== 8) begin
            failures++; $display("FAIL cap_wr_count: got %0d expected 8", wr_a.size() - b_wr);
        end
    endtask

    task automatic test_zero_err();
        int n, b_v, b_wr;
        lat = 1; ready_mode = 0;
        b_v = reqv_total; b_wr = wr_a.size();
        start_req(64'h1000, 18'h0, 16'd0);
        wait_ack(10, n);
        checks++;
        if ({n, err} !== {32'd1, 1'b0}) begin failures++; $display("FAIL zero_len: n %0d err %b expected 1 0", n, err); end
        release_fetch();
        start_req(64'h1000, 18'h0, 16'd65);
        wait_ack(10, n);
        checks++;
        if ({n, err} !== {32'd1, 1'b1}) begin failures++; $display("FAIL too_long: n %0d err %b expected 1 1", n, err); end
        release_fetch();
        start_req(64'h1002, 18'h0, 16'd4);
        wait_ack(10, n);
        checks++;
        if ({n, err} !== {32'd1, 1'b1}) begin failures++; $display("FAIL misaligned: n %0d err %b expected 1 1", n, err); end
        release_fetch();
        checks++;
        if ((reqv_total - b_v !== 0) || (wr_a.size() - b_wr !== 0)) begin
            failures++;
            $display("FAIL no_traffic: req cycles %0d writes %0d expected 0 0", reqv_total - b_v, wr_a.size() - b_wr);
        end
        start_req(64'h1000, 18'h0, 16'd1);
        wait_ack(20, n);
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL err_clear: got %b expected 0", err); end
        release_fetch();
    endtask

    task automatic test_hold_fetch();
        int n, b_ack;
        b_ack = ack_total;
        start_req(64'h1000, 18'h0, 16'd0);
        wait_ack(10, n);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({ack_fetch_data, busy} !== 2'b01) begin
                failures++; $display("FAIL hold_cycle%0d: ack,busy %b expected 01", i, {ack_fetch_data, busy});
            end
        end
        @(negedge clk);
        fetch_data = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL hold_release: busy %b expected 0", busy); end
        @(negedge clk);
        fetch_data = 1'b1;
        wait_ack(10, n);
        checks++;
        if (n !== 1) begin failures++; $display("FAIL rearm_latency: got %0d expected 1", n); end
        release_fetch();
        checks++;
        if (ack_total - b_ack !== 2) begin failures++; $display("FAIL hold_ack_count: got %0d expected 2", ack_total - b_ack); end
    endtask

    task automatic test_stray();
        int b_wr;
        b_wr = wr_a.size();
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL stray_pre_err: got %b expected 0", err); end
        @(negedge clk);
        inj_valid = 1'b1;
        @(negedge clk);
        inj_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({err, busy} !== 2'b10) begin failures++; $display("FAIL stray_err: err,busy %b expected 10", {err, busy}); end
        checks++;
        if (wr_a.size() - b_wr !== 0) begin failures++; $display("FAIL stray_write: got %0d expected 0", wr_a.size() - b_wr); end
    endtask

    task automatic test_reset_mid();
        int n, b_wr, b_ack, b_wr2;
        lat = 3; ready_mode = 0;
        b_wr = wr_a.size(); b_ack = ack_total;
        start_req(64'h4000, 18'h00400, 16'd8);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #2;
            if (wr_a.size() - b_wr >= 3) break;
        end
        rst = 1'b1;
        fetch_data = 1'b0;
        #1;
        checks++;
        if ({busy, ack_fetch_data, mem_req_valid, videomem_we, err, mem_req_addr, videomem_addr, videomem_wdata} !== 119'd0) begin
            failures++;
            $display("FAIL midreset_outputs: busy %b ack %b rv %b we %b err %b ra %h va %h vd %h expected all 0",
                     busy, ack_fetch_data, mem_req_valid, videomem_we, err, mem_req_addr, videomem_addr, videomem_wdata);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if ((ack_total - b_ack !== 0) || (wr_a.size() - b_wr !== 3)) begin
            failures++;
            $display("FAIL midreset_aftermath: acks %0d writes %0d expected 0 3", ack_total - b_ack, wr_a.size() - b_wr);
        end
        checks++;
        if (err !== 1'b1) begin failures++; $display("FAIL midreset_late_err: got %b expected 1", err); end
        b_wr2 = wr_a.size();
        start_req(64'h5000, 18'h00500, 16'd2);
        wait_ack(50, n);
        release_fetch();
        checks++;
        if ((wr_a.size() - b_wr2 !== 2) || (err !== 1'b0)) begin
            failures++; $display("FAIL post_reset_chunk: writes %0d err %b expected 2 0", wr_a.size() - b_wr2, err);
        end else begin
            checks++;
            if ({wr_a[b_wr2 + 1], wr_d[b_wr2 + 1]} !== {18'h00504, exp_data(64'h5004)}) begin
                failures++;
                $display("FAIL post_reset_data: wr %h data %h expected 00504 %h", wr_a[b_wr2 + 1], wr_d[b_wr2 + 1],
                         exp_data(64'h5004));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_max_len();
        test_backpressure();
        test_zero_err();
        test_hold_fetch();
        test_stray();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
